// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with single-cycle logic/arith/shift ops,
// an iterative shift-add multiplier and registered signed compare flags.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_out_hi,
    output logic             o_eq,
    output logic             o_lt,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH:0] W_LIM = (WIDTH + 1)'(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] OP_MUL = 4'd8;
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_lt;
    logic               w_big;
    logic               w_lt;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    always_comb begin
        w_big = {1'b0, i_b} >= W_LIM;
        w_lt  = $signed(i_a) < $signed(i_b);
        w_res = (i_op == 4'd0) ? i_a + i_b :
                (i_op == 4'd1) ? i_a - i_b :
                (i_op == 4'd2) ? i_a & i_b :
                (i_op == 4'd3) ? i_a | i_b :
                (i_op == 4'd4) ? i_a ^ i_b :
                (i_op == 4'd5) ? {{(WIDTH-1){1'b0}}, ^i_a} :
                (i_op == 4'd6) ? (w_big ? '0 : i_a << i_b) :
                (i_op == 4'd7) ? (w_big ? '0 : i_a >> i_b) : '0;
        // upper accumulator keeps its carry so the right shift never loses it
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_lt     <= 1'b0;
            o_out    <= '0;
            o_out_hi <= '0;
            o_eq     <= 1'b0;
            o_lt     <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_op == OP_MUL) begin
                        r_state <= S_MUL;
                        o_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_mcand <= i_a;
                        r_acc   <= {{WIDTH{1'b0}}, i_b};
                        r_lt    <= w_lt;
                    end else if (i_start) begin
                        o_out    <= w_res;
                        o_out_hi <= '0;
                        o_eq     <= w_res == '0;
                        o_lt     <= w_lt;
                        o_done   <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state  <= S_IDLE;
                        o_busy   <= 1'b0;
                        o_out    <= w_acc_nxt[WIDTH-1:0];
                        o_out_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                        o_eq     <= w_acc_nxt[WIDTH-1:0] == '0;
                        o_lt     <= r_lt;
                        o_done   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
